// File: rtl/moldudp_miss_msg_det.sv
// MoldUDP64 missed-message detector: tracks expected session/sequence and reports gaps.
// Optional simulation checks are compiled in with MISS_DET_ASSERT_EN.
module moldudp_miss_msg_det #(
  parameter int SEQ_NUM_W = 64,
  parameter int SID_W     = 80,
  parameter int ML_W      = 16,
  parameter logic [SID_W-1:0] SID_GAP_MAX = SID_W'(1) << (SEQ_NUM_W - 1)
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 v_i,
  input  logic [SID_W-1:0]     sid_i,
  input  logic [SEQ_NUM_W-1:0] seq_num_i,
  input  logic [ML_W-1:0]      msg_cnt_i,
  input  logic                 eos_i,
  output logic                 miss_seq_num_v_o,
  output logic [SID_W-1:0]     miss_seq_num_sid_o,
  output logic [SEQ_NUM_W-1:0] miss_seq_num_start_o,
  output logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_o,
  output logic                 miss_sid_v_o,
  output logic [SID_W-1:0]     miss_sid_start_o,
  output logic [SEQ_NUM_W-1:0] miss_sid_seq_num_start_o,
  output logic [SID_W-1:0]     miss_sid_cnt_o,
  output logic [SEQ_NUM_W-1:0] miss_sid_seq_num_end_o
);

  logic                 synced_q, synced_d;
  logic [SID_W-1:0]     exp_sid_q, exp_sid_d;
  logic [SEQ_NUM_W-1:0] exp_seq_q, exp_seq_d;

  logic [SEQ_NUM_W-1:0] end_seq;
  logic [SEQ_NUM_W-1:0] seq_gap;
  logic [SID_W-1:0]     sid_gap;
  logic                 accepted;
  logic                 seq_hit;
  logic                 sid_hit;

  always_comb begin
    synced_d  = synced_q;
    exp_sid_d = exp_sid_q;
    exp_seq_d = exp_seq_q;
    accepted  = 1'b0;
    seq_hit   = 1'b0;
    sid_hit   = 1'b0;
    end_seq   = seq_num_i + SEQ_NUM_W'(msg_cnt_i);
    seq_gap   = seq_num_i - exp_seq_q;
    sid_gap   = sid_i - exp_sid_q;

    if (v_i) begin
      if (!synced_q) begin
        accepted  = 1'b1;
        synced_d  = 1'b1;
        exp_sid_d = sid_i;
        exp_seq_d = end_seq;
      end else if (sid_i == exp_sid_q) begin
        accepted = 1'b1;
        if (seq_num_i > exp_seq_q) begin
          seq_hit   = 1'b1;
          exp_seq_d = end_seq;
        end else if (seq_num_i == exp_seq_q) begin
          exp_seq_d = end_seq;
        end else if (end_seq > exp_seq_q) begin
          // late packet that still carries messages beyond what we expected
          exp_seq_d = end_seq;
        end
      end else if (sid_i > exp_sid_q) begin
        accepted  = 1'b1;
        sid_hit   = (sid_gap <= SID_GAP_MAX);
        exp_sid_d = sid_i;
        exp_seq_d = end_seq;
      end
      // end-of-session overrides: next packet must be the first of the following session
      if (accepted && eos_i) begin
        exp_sid_d = sid_i + SID_W'(1);
        exp_seq_d = SEQ_NUM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      synced_q                 <= 1'b0;
      exp_sid_q                <= '0;
      exp_seq_q                <= SEQ_NUM_W'(1);
      miss_seq_num_v_o         <= 1'b0;
      miss_seq_num_sid_o       <= '0;
      miss_seq_num_start_o     <= '0;
      miss_seq_num_cnt_o       <= '0;
      miss_sid_v_o             <= 1'b0;
      miss_sid_start_o         <= '0;
      miss_sid_seq_num_start_o <= '0;
      miss_sid_cnt_o           <= '0;
      miss_sid_seq_num_end_o   <= '0;
    end else begin
      synced_q         <= synced_d;
      exp_sid_q        <= exp_sid_d;
      exp_seq_q        <= exp_seq_d;
      miss_seq_num_v_o <= seq_hit;
      miss_sid_v_o     <= sid_hit;
      if (seq_hit) begin
        miss_seq_num_sid_o   <= sid_i;
        miss_seq_num_start_o <= exp_seq_q;
        miss_seq_num_cnt_o   <= seq_gap;
      end
      if (sid_hit) begin
        miss_sid_start_o         <= exp_sid_q;
        miss_sid_seq_num_start_o <= exp_seq_q;
        miss_sid_cnt_o           <= sid_gap;
        miss_sid_seq_num_end_o   <= seq_num_i;
      end
    end
  end

`ifdef MISS_DET_ASSERT_EN
  logic [SEQ_NUM_W-1:0] seq_report_end;
  assign seq_report_end = miss_seq_num_start_o + miss_seq_num_cnt_o;

  always @(posedge clk) begin
    if (!nreset) begin
      assert (!$isunknown(v_i)) else $error("v_i is X");
      assert (!(miss_seq_num_v_o && miss_sid_v_o)) else $error("both miss valids high");
      if (miss_seq_num_v_o) begin
        assert (miss_seq_num_cnt_o != '0) else $error("zero seq miss count");
        assert (miss_seq_num_start_o < seq_report_end) else $error("seq miss range wraps");
      end
      if (miss_sid_v_o)
        assert (miss_sid_cnt_o != '0) else $error("zero sid miss count");
    end
  end
`endif

endmodule

// File: tb/tb_moldudp_miss_msg_det.sv
// Directed bench for moldudp_miss_msg_det: hand-computed miss reports and state tracking.
module tb_moldudp_miss_msg_det;
  localparam int SEQ_NUM_W = 64;
  localparam int SID_W     = 80;
  localparam int ML_W      = 16;

  logic                 clk = 1'b0;
  logic                 nreset;
  logic                 v_i;
  logic [SID_W-1:0]     sid_i;
  logic [SEQ_NUM_W-1:0] seq_num_i;
  logic [ML_W-1:0]      msg_cnt_i;
  logic                 eos_i;
  logic                 miss_seq_num_v_o;
  logic [SID_W-1:0]     miss_seq_num_sid_o;
  logic [SEQ_NUM_W-1:0] miss_seq_num_start_o;
  logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_o;
  logic                 miss_sid_v_o;
  logic [SID_W-1:0]     miss_sid_start_o;
  logic [SEQ_NUM_W-1:0] miss_sid_seq_num_start_o;
  logic [SID_W-1:0]     miss_sid_cnt_o;
  logic [SEQ_NUM_W-1:0] miss_sid_seq_num_end_o;

  int total = 0;
  int bad   = 0;

  logic [SID_W-1:0] sid_one;
  logic [SID_W-1:0] sid_big;
  logic [SID_W-1:0] sid_edge;
  logic [SID_W-1:0] half;

  moldudp_miss_msg_det #(
    .SEQ_NUM_W(SEQ_NUM_W), .SID_W(SID_W), .ML_W(ML_W)
  ) dut (
    .clk(clk), .nreset(nreset), .v_i(v_i), .sid_i(sid_i), .seq_num_i(seq_num_i),
    .msg_cnt_i(msg_cnt_i), .eos_i(eos_i),
    .miss_seq_num_v_o(miss_seq_num_v_o), .miss_seq_num_sid_o(miss_seq_num_sid_o),
    .miss_seq_num_start_o(miss_seq_num_start_o), .miss_seq_num_cnt_o(miss_seq_num_cnt_o),
    .miss_sid_v_o(miss_sid_v_o), .miss_sid_start_o(miss_sid_start_o),
    .miss_sid_seq_num_start_o(miss_sid_seq_num_start_o), .miss_sid_cnt_o(miss_sid_cnt_o),
    .miss_sid_seq_num_end_o(miss_sid_seq_num_end_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one packet at a negedge; return at the following negedge, after the
  // registered report for it is visible.
  task automatic send(input logic [SID_W-1:0] sid, input logic [SEQ_NUM_W-1:0] seq,
                      input logic [ML_W-1:0] cnt, input logic eos);
    @(negedge clk);
    v_i = 1'b1; sid_i = sid; seq_num_i = seq; msg_cnt_i = cnt; eos_i = eos;
    @(negedge clk);
    v_i = 1'b0; eos_i = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic expect_none(input string tag);
    check({tag, ".seq_v"}, 128'(miss_seq_num_v_o), 128'(0));
    check({tag, ".sid_v"}, 128'(miss_sid_v_o), 128'(0));
  endtask

  task automatic expect_seq(input string tag, input logic [SID_W-1:0] sid,
                            input logic [SEQ_NUM_W-1:0] start, input logic [SEQ_NUM_W-1:0] cnt);
    check({tag, ".seq_v"}, 128'(miss_seq_num_v_o), 128'(1));
    check({tag, ".sid_v"}, 128'(miss_sid_v_o), 128'(0));
    check({tag, ".sid"}, 128'(miss_seq_num_sid_o), 128'(sid));
    check({tag, ".start"}, 128'(miss_seq_num_start_o), 128'(start));
    check({tag, ".cnt"}, 128'(miss_seq_num_cnt_o), 128'(cnt));
  endtask

  task automatic expect_sid(input string tag, input logic [SID_W-1:0] start,
                            input logic [SEQ_NUM_W-1:0] seq_start, input logic [SID_W-1:0] cnt,
                            input logic [SEQ_NUM_W-1:0] seq_end);
    check({tag, ".sid_v"}, 128'(miss_sid_v_o), 128'(1));
    check({tag, ".seq_v"}, 128'(miss_seq_num_v_o), 128'(0));
    check({tag, ".start"}, 128'(miss_sid_start_o), 128'(start));
    check({tag, ".seq_start"}, 128'(miss_sid_seq_num_start_o), 128'(seq_start));
    check({tag, ".cnt"}, 128'(miss_sid_cnt_o), 128'(cnt));
    check({tag, ".seq_end"}, 128'(miss_sid_seq_num_end_o), 128'(seq_end));
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    nreset = 1'b0;
  endtask

  initial begin
    nreset = 1'b1; v_i = 1'b0; sid_i = '0; seq_num_i = '0; msg_cnt_i = '0; eos_i = 1'b0;
    half     = 80'd1 << 63;
    sid_one  = 80'd1;
    sid_big  = sid_one + half + 80'd1;
    sid_edge = sid_big + half;
    repeat (3) @(negedge clk);
    nreset = 1'b0;

    // reset values
    expect_none("rst");
    check("rst.seq_start", 128'(miss_seq_num_start_o), 128'(0));
    check("rst.sid_cnt", 128'(miss_sid_cnt_o), 128'(0));

    // in-session tracking and gap
    send(80'd5, 64'd1, 16'd3, 1'b0);  expect_none("sync");
    send(80'd5, 64'd4, 16'd2, 1'b0);  expect_none("inorder");
    send(80'd5, 64'd10, 16'd1, 1'b0); expect_seq("gap", 80'd5, 64'd6, 64'd4);
    idle();
    check("gap.pulse_end", 128'(miss_seq_num_v_o), 128'(0));
    check("gap.hold_start", 128'(miss_seq_num_start_o), 128'(6));
    check("gap.hold_cnt", 128'(miss_seq_num_cnt_o), 128'(4));

    // session jump
    send(80'd7, 64'd3, 16'd1, 1'b0);
    expect_sid("jump", 80'd5, 64'd11, 80'd2, 64'd3);
    send(80'd7, 64'd4, 16'd1, 1'b1);  expect_none("eos");
    send(80'd8, 64'd1, 16'd2, 1'b0);  expect_none("newsess");
    send(80'd8, 64'd1, 16'd2, 1'b0);  expect_none("dup");
    // heartbeat at expected seq leaves exp_seq at 3; then a gap exposes it
    send(80'd8, 64'd3, 16'd0, 1'b0);  expect_none("hb_ok");
    send(80'd8, 64'd5, 16'd0, 1'b0);  expect_seq("hb_gap", 80'd8, 64'd3, 64'd2);
    send(80'd8, 64'd5, 16'd1, 1'b0);  expect_none("after_hb");

    // resync on huge session jump, stale packet ignored
    do_reset();
    send(sid_one, 64'd1, 16'd1, 1'b0);  expect_none("rs.sync");
    send(sid_big, 64'd10, 16'd1, 1'b0); expect_none("rs.resync");
    send(80'd0, 64'd100, 16'd5, 1'b0);  expect_none("rs.stale");
    send(sid_big, 64'd11, 16'd0, 1'b0); expect_none("rs.cont");
    send(sid_big, 64'd13, 16'd1, 1'b0); expect_seq("rs.gap", sid_big, 64'd11, 64'd2);
    // session gap exactly at the limit is still reported
    send(sid_edge, 64'd7, 16'd1, 1'b0);
    expect_sid("edge", sid_big, 64'd14, half, 64'd7);

    // reset mid-traffic drops the packet in the reset cycle
    @(negedge clk);
    nreset = 1'b1; v_i = 1'b1; sid_i = sid_edge; seq_num_i = 64'd50; msg_cnt_i = 16'd1;
    @(negedge clk);
    nreset = 1'b0; v_i = 1'b0;
    expect_none("mid_rst");
    check("mid_rst.sid_start", 128'(miss_sid_start_o), 128'(0));
    check("mid_rst.sid_cnt", 128'(miss_sid_cnt_o), 128'(0));
    check("mid_rst.seq_cnt", 128'(miss_seq_num_cnt_o), 128'(0));
    send(80'd9, 64'd50, 16'd1, 1'b0); expect_none("post_rst.sync");
    // report and end-of-session on the same packet
    send(80'd9, 64'd53, 16'd1, 1'b1); expect_seq("eos_gap", 80'd9, 64'd51, 64'd2);
    send(80'd10, 64'd1, 16'd1, 1'b0); expect_none("eos_next");
    send(80'd10, 64'd2, 16'd1, 1'b0); expect_none("eos_next2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
